// File: rtl/hd44780_responder_if.sv
// HD44780 LCD bus as seen between a display driver (master) and the responder (slave).
// The readback pair lcd_dout/lcd_doe is driven only when LCD_READBACK_EN is defined.
interface hd44780_responder_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_dout;
    logic       lcd_doe;

    modport master (output lcd_data, lcd_rs, lcd_rw, lcd_e, input lcd_dout, lcd_doe);
    modport slave  (input lcd_data, lcd_rs, lcd_rw, lcd_e, output lcd_dout, lcd_doe);
endinterface

// File: rtl/hd44780_responder.sv
// HD44780 bus responder: decodes the LCD bus, keeps a 2x16 character mirror, checks timing.
// Optional macro LCD_READBACK_EN enables busy/AC and data reads on the bus.
module hd44780_responder #(
    parameter int T_POR = 750_000,
    parameter int T_CMD = 1_850,
    parameter int T_CLR = 76_000
) (
    input  logic                      CLOCK_50,
    input  logic                      rst,
    hd44780_responder_if.slave        lcd,
    input  logic [4:0]                rd_addr,
    output logic [7:0]                rd_char,
    output logic [6:0]                cursor_addr,
    output logic                      display_on,
    output logic                      init_done,
    output logic                      busy_flag,
    output logic                      viol_pulse
);
    localparam int POR_W  = $clog2(T_POR + 1);
    localparam int BUSY_W = $clog2(T_CLR + 1);
    localparam logic [BUSY_W-1:0] CMD_LOAD = BUSY_W'(T_CMD);
    localparam logic [BUSY_W-1:0] CLR_LOAD = BUSY_W'(T_CLR);

    typedef enum logic [1:0] {S_POR, S_INIT, S_READY} state_t;

    state_t              state_reg, state_next;
    logic [POR_W-1:0]    por_cnt_reg, por_cnt_next;
    logic [BUSY_W-1:0]   busy_cnt_reg, busy_cnt_next;
    logic [5:0]          fill_cnt_reg, fill_cnt_next;
    logic [6:0]          ac_reg, ac_next;
    logic                id_reg, id_next;
    logic                cg_reg, cg_next;
    logic                disp_reg, disp_next;
    logic                init_reg, init_next;
    logic                seen_reg, seen_next;
    logic                viol_reg, viol_next;

    logic                e_meta_reg, e_sync_reg, e_prev_reg;
    logic                strobe_reg;
    logic [7:0]          cmd_data_reg;
    logic                cmd_rs_reg, cmd_rw_reg;

    logic [7:0]          mirror [0:31];
    logic [7:0]          rd_char_reg;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [7:0]          wr_data;

    // Only 0x00-0x0F and 0x40-0x4F are visible on a 2x16 panel.
    logic                on_screen;
    logic [4:0]          ac_index;
    assign on_screen = (ac_reg[5:4] == 2'b00);
    assign ac_index  = {ac_reg[6], ac_reg[3:0]};

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == 7'h27)      return 7'h40;
            else if (ac == 7'h67) return 7'h00;
            else                  return ac + 7'd1;
        end else begin
            if (ac == 7'h00)      return 7'h67;
            else if (ac == 7'h40) return 7'h27;
            else                  return ac - 7'd1;
        end
    endfunction

    // E is asynchronous: synchronize, then latch the bus on the synchronized falling edge.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            e_meta_reg   <= 1'b0;
            e_sync_reg   <= 1'b0;
            e_prev_reg   <= 1'b0;
            strobe_reg   <= 1'b0;
            cmd_data_reg <= 8'h00;
            cmd_rs_reg   <= 1'b0;
            cmd_rw_reg   <= 1'b0;
        end else begin
            e_meta_reg <= lcd.lcd_e;
            e_sync_reg <= e_meta_reg;
            e_prev_reg <= e_sync_reg;
            strobe_reg <= e_prev_reg & ~e_sync_reg;
            if (e_prev_reg & ~e_sync_reg) begin
                cmd_data_reg <= lcd.lcd_data;
                cmd_rs_reg   <= lcd.lcd_rs;
                cmd_rw_reg   <= lcd.lcd_rw;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_reg    <= S_POR;
            por_cnt_reg  <= '0;
            busy_cnt_reg <= '0;
            fill_cnt_reg <= 6'd0;
            ac_reg       <= 7'h00;
            id_reg       <= 1'b1;
            cg_reg       <= 1'b0;
            disp_reg     <= 1'b0;
            init_reg     <= 1'b0;
            seen_reg     <= 1'b0;
            viol_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            por_cnt_reg  <= por_cnt_next;
            busy_cnt_reg <= busy_cnt_next;
            fill_cnt_reg <= fill_cnt_next;
            ac_reg       <= ac_next;
            id_reg       <= id_next;
            cg_reg       <= cg_next;
            disp_reg     <= disp_next;
            init_reg     <= init_next;
            seen_reg     <= seen_next;
            viol_reg     <= viol_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        por_cnt_next  = por_cnt_reg;
        busy_cnt_next = busy_cnt_reg;
        fill_cnt_next = fill_cnt_reg;
        ac_next       = ac_reg;
        id_next       = id_reg;
        cg_next       = cg_reg;
        disp_next     = disp_reg;
        init_next     = init_reg;
        seen_next     = seen_reg;
        viol_next     = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = fill_cnt_reg[4:0];
        wr_data       = 8'h20;

        if (busy_cnt_reg != '0)
            busy_cnt_next = busy_cnt_reg - 1'b1;
        // Space fill runs one entry per cycle after reset and after a clear.
        if (!fill_cnt_reg[5]) begin
            wr_en         = 1'b1;
            fill_cnt_next = fill_cnt_reg + 6'd1;
        end

        case (state_reg)
            S_POR: begin
                if (por_cnt_reg == POR_W'(T_POR - 1))
                    state_next = S_INIT;
                else
                    por_cnt_next = por_cnt_reg + 1'b1;
                if (strobe_reg)
                    viol_next = 1'b1;
            end
            S_INIT: if (strobe_reg) begin
                if (cmd_rs_reg || cmd_rw_reg || cmd_data_reg[7:4] != 4'h3)
                    viol_next = 1'b1;
                else if (seen_reg && cmd_data_reg == 8'h38) begin
                    init_next  = 1'b1;
                    state_next = S_READY;
                end else
                    seen_next = 1'b1;
            end
            S_READY: if (strobe_reg) begin
                // A count of 1 is the final busy cycle, so a strobe then is accepted.
                if (cmd_rw_reg) begin
`ifdef LCD_READBACK_EN
                    if (cmd_rs_reg) begin
                        if (busy_cnt_reg > BUSY_W'(1))
                            viol_next = 1'b1;
                        else begin
                            busy_cnt_next = CMD_LOAD;
                            if (!cg_reg)
                                ac_next = ac_step(ac_reg, id_reg);
                        end
                    end
`else
                    viol_next = 1'b1;
`endif
                end else if (busy_cnt_reg > BUSY_W'(1)) begin
                    viol_next = 1'b1;
                end else if (cmd_rs_reg) begin
                    busy_cnt_next = CMD_LOAD;
                    if (!cg_reg) begin
                        if (on_screen) begin
                            wr_en   = 1'b1;
                            wr_addr = ac_index;
                            wr_data = cmd_data_reg;
                        end
                        ac_next = ac_step(ac_reg, id_reg);
                    end
                end else begin
                    busy_cnt_next = CMD_LOAD;
                    // S, C, B, DL, N and F have no visible effect on the mirror, so they are not kept.
                    casez (cmd_data_reg)
                        8'b1???????: begin ac_next = cmd_data_reg[6:0]; cg_next = 1'b0; end
                        8'b01??????: cg_next = 1'b1;
                        8'b001?????: if (cmd_data_reg != 8'h38) viol_next = 1'b1;
                        8'b0001????: if (!cmd_data_reg[3]) ac_next = ac_step(ac_reg, cmd_data_reg[2]);
                        8'b00001???: disp_next = cmd_data_reg[2];
                        8'b000001??: id_next = cmd_data_reg[1];
                        8'b0000001?: begin ac_next = 7'h00; busy_cnt_next = CLR_LOAD; end
                        8'b00000001: begin
                            ac_next       = 7'h00;
                            id_next       = 1'b1;
                            fill_cnt_next = 6'd0;
                            busy_cnt_next = CLR_LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = S_POR;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mirror[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst)
            rd_char_reg <= 8'h00;
        else
            rd_char_reg <= mirror[rd_addr];
    end

`ifdef LCD_READBACK_EN
    logic [7:0] rb_char_reg;
    always_ff @(posedge CLOCK_50) begin
        if (rst)
            rb_char_reg <= 8'h00;
        else
            rb_char_reg <= on_screen ? mirror[ac_index] : 8'h20;
    end
    assign lcd.lcd_doe  = e_sync_reg & lcd.lcd_rw;
    assign lcd.lcd_dout = lcd.lcd_rs ? rb_char_reg : {busy_flag, ac_reg};
`else
    assign lcd.lcd_doe  = 1'b0;
    assign lcd.lcd_dout = 8'h00;
`endif

    assign rd_char     = rd_char_reg;
    assign cursor_addr = ac_reg;
    assign display_on  = disp_reg;
    assign init_done   = init_reg;
    assign busy_flag   = (busy_cnt_reg != '0);
    assign viol_pulse  = viol_reg;
endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder with shortened timing parameters.
module tb_hd44780_responder;
    localparam int T_POR = 200;
    localparam int T_CMD = 40;
    localparam int T_CLR = 100;
    localparam int GAP   = T_CLR + 10;

    logic       CLOCK_50 = 1'b0;
    logic       rst;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       display_on, init_done, busy_flag, viol_pulse;

    int checks = 0;
    int errors = 0;
    int viol_cnt = 0;
    int viol_base;
    logic [7:0] v;

    hd44780_responder_if lcd();

    hd44780_responder #(.T_POR(T_POR), .T_CMD(T_CMD), .T_CLR(T_CLR)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .lcd        (lcd),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cursor_addr(cursor_addr),
        .display_on (display_on),
        .init_done  (init_done),
        .busy_flag  (busy_flag),
        .viol_pulse (viol_pulse)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (viol_pulse) viol_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic lcd_write(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge CLOCK_50);
        lcd.lcd_data = d; lcd.lcd_rs = rs; lcd.lcd_rw = rw; lcd.lcd_e = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        lcd.lcd_e = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        lcd.lcd_rw = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        lcd_write(1'b0, 1'b0, d);
        repeat (GAP) @(negedge CLOCK_50);
    endtask

    task automatic dat(input logic [7:0] d);
        lcd_write(1'b1, 1'b0, d);
        repeat (GAP) @(negedge CLOCK_50);
    endtask

    task automatic read_char(input logic [4:0] a, output logic [7:0] val);
        @(negedge CLOCK_50);
        rd_addr = a;
        @(negedge CLOCK_50);
        val = rd_char;
    endtask

    initial begin
        string word;
        word = "Please";
        rst = 1'b1; rd_addr = 5'd0;
        lcd.lcd_data = 8'h00; lcd.lcd_rs = 1'b0; lcd.lcd_rw = 1'b0; lcd.lcd_e = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // Reset state
        check("rst_cursor", cursor_addr, 7'h00);
        check("rst_display", display_on, 1'b0);
        check("rst_init", init_done, 1'b0);
        check("rst_busy", busy_flag, 1'b0);
        check("rst_viol", viol_pulse, 1'b0);
        check("rst_rdchar", rd_char, 8'h00);
        rst = 1'b0;

        // Early access inside the power-on window
        repeat (50) @(negedge CLOCK_50);
        viol_base = viol_cnt;
        lcd_write(1'b0, 1'b0, 8'h30);
        repeat (3) @(negedge CLOCK_50);
        check("early_viol", viol_cnt - viol_base, 1);
        repeat (T_POR) @(negedge CLOCK_50);
        check("por_no_init", init_done, 1'b0);

        // Init: lone 0x38 only arms, non-0x3x is rejected, then 0x38 completes
        viol_base = viol_cnt;
        cmd(8'h38);
        check("first38_no_init", init_done, 1'b0);
        cmd(8'h80);
        check("init_bad_viol", viol_cnt - viol_base, 1);
        cmd(8'h30); cmd(8'h30); cmd(8'h30);
        cmd(8'h38);
        check("init_done", init_done, 1'b1);
        cmd(8'h08);
        lcd_write(1'b0, 1'b0, 8'h01);
        check("clear_busy", busy_flag, 1'b1);
        repeat (GAP) @(negedge CLOCK_50);
        cmd(8'h06);
        cmd(8'h0C);
        check("display_on", display_on, 1'b1);
        check("init_viol_total", viol_cnt - viol_base, 1);
        check("init_cursor", cursor_addr, 7'h00);
        for (int i = 0; i < 32; i++) begin
            read_char(i[4:0], v);
            check($sformatf("space[%0d]", i), v, 8'h20);
        end

        // Line writes
        cmd(8'h80);
        for (int i = 0; i < 6; i++) dat(word[i]);
        for (int i = 0; i < 6; i++) begin
            read_char(i[4:0], v);
            check($sformatf("line1[%0d]", i), v, word[i]);
        end
        check("line1_cursor", cursor_addr, 7'h06);
        cmd(8'hC0);
        dat(8'h63);
        read_char(5'd16, v);
        check("line2_c", v, 8'h63);
        check("line2_cursor", cursor_addr, 7'h41);

        // Wraps
        cmd(8'hA7);
        dat("X");
        check("wrap_27", cursor_addr, 7'h40);
        read_char(5'd16, v);
        check("wrap_27_keep16", v, 8'h63);
        read_char(5'd0, v);
        check("wrap_27_keep0", v, "P");
        cmd(8'hE7);
        dat("Y");
        check("wrap_67", cursor_addr, 7'h00);
        cmd(8'h04);
        dat("Z");
        read_char(5'd0, v);
        check("dec_write", v, "Z");
        check("dec_wrap_00", cursor_addr, 7'h67);
        dat("W");
        check("dec_offscreen", cursor_addr, 7'h66);
        cmd(8'h06);

        // CGRAM mode discards data, DDRAM address leaves it
        cmd(8'h40);
        dat("Q");
        check("cg_cursor", cursor_addr, 7'h66);
        cmd(8'h80);
        dat("R");
        read_char(5'd0, v);
        check("ddram_back", v, "R");

        // Shifts
        cmd(8'h14);
        check("shift_right", cursor_addr, 7'h02);
        cmd(8'h10);
        check("shift_left", cursor_addr, 7'h01);
        cmd(8'h18);
        check("shift_display_noop", cursor_addr, 7'h01);

        // Function set other than 0x38 and a read strobe both flag
        viol_base = viol_cnt;
        cmd(8'h30);
        check("funcset_viol", viol_cnt - viol_base, 1);
        cmd(8'h38);
        check("funcset_ok", viol_cnt - viol_base, 1);
        lcd_write(1'b0, 1'b1, 8'h00);
        repeat (GAP) @(negedge CLOCK_50);
        check("read_viol", viol_cnt - viol_base, 2);
        check("read_cursor", cursor_addr, 7'h01);
        check("readback_doe", lcd.lcd_doe, 1'b0);

        // Busy violation during clear
        viol_base = viol_cnt;
        lcd_write(1'b0, 1'b0, 8'h01);
        repeat (30) @(negedge CLOCK_50);
        lcd_write(1'b0, 1'b0, 8'h85);
        repeat (GAP) @(negedge CLOCK_50);
        check("busy_viol", viol_cnt - viol_base, 1);
        check("busy_drop_cursor", cursor_addr, 7'h00);
        read_char(5'd0, v);
        check("clear_0", v, 8'h20);
        read_char(5'd16, v);
        check("clear_16", v, 8'h20);

        // Reset in the middle of a clear
        lcd_write(1'b0, 1'b0, 8'h01);
        repeat (20) @(negedge CLOCK_50);
        check("midclear_busy", busy_flag, 1'b1);
        rst = 1'b1;
        @(negedge CLOCK_50);
        check("midrst_init", init_done, 1'b0);
        check("midrst_busy", busy_flag, 1'b0);
        check("midrst_display", display_on, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        viol_base = viol_cnt;
        lcd_write(1'b0, 1'b0, 8'h30);
        repeat (3) @(negedge CLOCK_50);
        check("por_restart_viol", viol_cnt - viol_base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
